// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg: shared definitions for the coprocessor-0 block.
//   - cp0_oper_e   : command codes issued by the pipeline controller
//   - Cp0*         : CP0 register numbers used by MFC0/MTC0
//   - Status*Bit   : STATUS field positions, CauseIpBit : pending flag in CAUSE
//   - cp0_state_e  : interrupt FSM states (EXL mirrors StHandler)
package cp0_unit_pkg;

   typedef enum logic [1:0] {
      ExeCpNone  = 2'd0,
      ExeCpStore = 2'd1,
      ExeCp0Eret = 2'd2,
      ExeCpRsvd  = 2'd3
   } cp0_oper_e;

   localparam logic [4:0] Cp0Status = 5'd12;
   localparam logic [4:0] Cp0Cause  = 5'd13;
   localparam logic [4:0] Cp0Epc    = 5'd14;
   localparam logic [4:0] Cp0Ehbr   = 5'd15;

   localparam int unsigned StatusIeBit  = 0;
   localparam int unsigned StatusExlBit = 1;
   localparam int unsigned CauseIpBit   = 31;

   typedef enum logic {
      StRun     = 1'b0,
      StHandler = 1'b1
   } cp0_state_e;

endpackage

// File: rtl/cp0_unit_irq_sync.sv
// cp0_unit_irq_sync: multi-flop synchroniser for an asynchronous interrupt level,
// followed by a rising-edge detector.
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset, clears the whole chain
//   irq_i       : asynchronous interrupt request level
//   irq_pulse_o : one-cycle pulse per synchronised rising edge
module cp0_unit_irq_sync #(
   parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic irq_i,
   output logic irq_pulse_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   seen_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         seen_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
         seen_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign irq_pulse_o = sync_q[SYNC_STAGES-1] & ~seen_q;

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor 0 for the 5-stage MIPS pipeline.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   en_i                 : stage enable; no state change and no redirect when low
//   oper_i               : NONE / STORE (MTC0) / ERET / reserved(=NONE)
//   addr_r_i, data_r_o   : MFC0 read port (combinational, committed values)
//   addr_w_i, data_w_i   : MTC0 write port
//   ret_addr_i           : PC of the instruction in ID, saved to EPC on interrupt
//   ret_valid_i          : ID holds a valid unstalled instruction
//   ir_i                 : asynchronous external interrupt level
//   jump_en_o/jump_addr_o: fetch redirect on interrupt entry or ERET
module cp0_unit
   import cp0_unit_pkg::*;
#(
   parameter logic [31:0] HANDLER_RESET = 32'h0000_0008,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic [1:0]  oper_i,
   input  logic [4:0]  addr_r_i,
   output logic [31:0] data_r_o,
   input  logic [4:0]  addr_w_i,
   input  logic [31:0] data_w_i,
   input  logic [31:0] ret_addr_i,
   input  logic        ret_valid_i,
   input  logic        ir_i,
   output logic        jump_en_o,
   output logic [31:0] jump_addr_o
);

   cp0_state_e  state_q, state_d;
   logic        ie_q, ie_d;
   logic        ip_q, ip_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] ehbr_q, ehbr_d;

   logic irq_pulse;
   logic exl, store, eret, take_int;

   cp0_unit_irq_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_irq_sync (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .irq_i       (ir_i),
      .irq_pulse_o (irq_pulse)
   );

   assign exl      = (state_q == StHandler);
   assign store    = en_i && (oper_i == ExeCpStore);
   assign eret     = en_i && (oper_i == ExeCp0Eret);
   assign take_int = en_i & ip_q & ie_q & ~exl & ret_valid_i & (oper_i != ExeCp0Eret);

   // Redirect is forced low while reset is asserted, even if ERET is presented.
   assign jump_en_o   = rst_ni & (take_int | eret);
   assign jump_addr_o = take_int ? ehbr_q : epc_q;

   always_comb begin
      data_r_o = '0;
      case (addr_r_i)
         Cp0Status: begin
            data_r_o[StatusIeBit]  = ie_q;
            data_r_o[StatusExlBit] = exl;
         end
         Cp0Cause:  data_r_o[CauseIpBit] = ip_q;
         Cp0Epc:    data_r_o = epc_q;
         Cp0Ehbr:   data_r_o = ehbr_q;
         default:   data_r_o = '0;
      endcase
   end

   // Ordering below sets priority: interrupt entry overrides an MTC0 to EXL/EPC,
   // but the written IE bit survives.
   always_comb begin
      state_d = state_q;
      ie_d    = ie_q;
      epc_d   = epc_q;
      ehbr_d  = ehbr_q;
      if (store) begin
         case (addr_w_i)
            Cp0Status: begin
               ie_d    = data_w_i[StatusIeBit];
               state_d = data_w_i[StatusExlBit] ? StHandler : StRun;
            end
            Cp0Epc:    epc_d  = data_w_i;
            Cp0Ehbr:   ehbr_d = data_w_i;
            default:   ;
         endcase
      end
      if (take_int) begin
         epc_d   = ret_addr_i;
         state_d = StHandler;
      end
      if (eret) begin
         state_d = StRun;
      end
      // Pending flag captures edges regardless of en_i so no request is dropped;
      // a fresh edge in the clearing cycle keeps it set.
      ip_d = irq_pulse | (ip_q & ~take_int);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StRun;
         ie_q    <= 1'b0;
         ip_q    <= 1'b0;
         epc_q   <= '0;
         ehbr_q  <= HANDLER_RESET;
      end else begin
         state_q <= state_d;
         ie_q    <= ie_d;
         ip_q    <= ip_d;
         epc_q   <= epc_d;
         ehbr_q  <= ehbr_d;
      end
   end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed plus randomized bench for cp0_unit against a register-level
// reference model of the CP0 rules.
module tb_cp0_unit;

   localparam int unsigned S  = 2;
   localparam logic [31:0] HR = 32'h0000_0008;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [1:0]  oper;
   logic [4:0]  addr_r, addr_w;
   logic [31:0] data_r, data_w, ret_addr, jump_addr;
   logic        ret_valid, ir_in, jump_en;

   int checks = 0;
   int errors = 0;
   int njumps = 0;

   // Reference model: architectural registers plus a delay line of sampled ir_in.
   bit          m_ie, m_exl, m_ip;
   logic [31:0] m_epc, m_ehbr;
   logic [S:0]  m_hist;

   always #10 clk = ~clk;

   cp0_unit #(
      .HANDLER_RESET (HR),
      .SYNC_STAGES   (S)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_i        (en),
      .oper_i      (oper),
      .addr_r_i    (addr_r),
      .data_r_o    (data_r),
      .addr_w_i    (addr_w),
      .data_w_i    (data_w),
      .ret_addr_i  (ret_addr),
      .ret_valid_i (ret_valid),
      .ir_i        (ir_in),
      .jump_en_o   (jump_en),
      .jump_addr_o (jump_addr)
   );

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return {30'd0, m_exl, m_ie};
         5'd13:   return {m_ip, 31'd0};
         5'd14:   return m_epc;
         5'd15:   return m_ehbr;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_ie = 0; m_exl = 0; m_ip = 0; m_epc = '0; m_ehbr = HR; m_hist = '0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
      addr_r = a;
      #1;
      chk(tag, data_r, exp);
   endtask

   task automatic drive(input logic e, input logic [1:0] op, input logic [4:0] aw,
                        input logic [31:0] dw, input logic rv, input logic [31:0] ra);
      en = e; oper = op; addr_w = aw; data_w = dw; ret_valid = rv; ret_addr = ra;
   endtask

   // One clock cycle: check combinational outputs, then advance DUT and model.
   task automatic step();
      bit          take, exp_j, pulse, st, er;
      logic [31:0] exp_a;
      #1;
      take  = en && m_ip && m_ie && !m_exl && ret_valid && (oper != 2'd2);
      er    = en && (oper == 2'd2);
      st    = en && (oper == 2'd1);
      exp_j = take || er;
      exp_a = take ? m_ehbr : m_epc;
      chk("jump_en", 32'(jump_en), 32'(exp_j));
      if (exp_j) chk("jump_addr", jump_addr, exp_a);
      chk("data_r", data_r, m_read(addr_r));
      if (jump_en) njumps++;
      pulse = m_hist[S-1] & ~m_hist[S];
      @(posedge clk);
      if (st) begin
         if (addr_w == 5'd12) begin m_ie = data_w[0]; m_exl = data_w[1]; end
         if (addr_w == 5'd14) m_epc = data_w;
         if (addr_w == 5'd15) m_ehbr = data_w;
      end
      if (take) begin m_epc = ret_addr; m_exl = 1; end
      if (er) m_exl = 0;
      m_ip   = pulse || (m_ip && !take);
      m_hist = {m_hist[S-1:0], ir_in};
      @(negedge clk);
   endtask

   // Produce a synchronised rising edge on ir_in and wait until IP has latched it.
   task automatic raise_irq();
      ir_in = 1'b0;
      repeat (3) step();
      ir_in = 1'b1;
      repeat (4) step();
   endtask

   initial begin
      rst_n = 1'b0; ir_in = 1'b0; addr_r = '0;
      drive(1'b1, 2'd2, '0, '0, 1'b0, '0);
      model_reset();
      @(negedge clk);
      #1;
      chk("jump_en_in_reset", 32'(jump_en), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 2'd0, '0, '0, 1'b0, '0);
      rd(5'd12, "reset_status", 32'h0);
      rd(5'd14, "reset_epc", 32'h0);
      rd(5'd15, "reset_ehbr", 32'h8);
      step();

      // Enable interrupts, then take one.
      drive(1'b1, 2'd1, 5'd12, 32'h1, 1'b0, '0);
      step();
      drive(1'b1, 2'd0, '0, '0, 1'b1, 32'h40);
      ir_in = 1'b1;
      njumps = 0;
      repeat (5) step();
      chk("entry_pulse_count", 32'(njumps), 32'd1);
      rd(5'd14, "entry_epc", 32'h40);
      rd(5'd12, "entry_status", 32'h3);
      rd(5'd13, "entry_cause", 32'h0);

      // New request inside handler stays pending; ERET returns, then it is taken.
      njumps = 0;
      raise_irq();
      chk("handler_no_redirect", 32'(njumps), 32'd0);
      rd(5'd13, "handler_cause", 32'h8000_0000);
      oper = 2'd2;
      #1;
      chk("eret_jump_en", 32'(jump_en), 32'd1);
      chk("eret_jump_addr", jump_addr, 32'h40);
      step();
      oper = 2'd0;
      rd(5'd12, "eret_status", 32'h1);
      chk("pending_taken_en", 32'(jump_en), 32'd1);
      chk("pending_taken_addr", jump_addr, 32'h8);
      step();

      // Deferral while ret_valid is low.
      oper = 2'd2;
      step();
      drive(1'b1, 2'd0, '0, '0, 1'b0, 32'h40);
      raise_irq();
      njumps = 0;
      repeat (5) step();
      chk("deferred_no_redirect", 32'(njumps), 32'd0);
      ret_valid = 1'b1; ret_addr = 32'h1234;
      #1;
      chk("deferred_taken_en", 32'(jump_en), 32'd1);
      step();
      ret_valid = 1'b0;
      rd(5'd14, "deferred_epc", 32'h1234);
      rd(5'd12, "deferred_status", 32'h3);

      // Move EHBR, then collide an MTC0 EPC with interrupt entry.
      oper = 2'd2;
      step();
      drive(1'b1, 2'd1, 5'd15, 32'h300, 1'b0, '0);
      step();
      drive(1'b1, 2'd0, '0, '0, 1'b0, '0);
      raise_irq();
      drive(1'b1, 2'd1, 5'd14, 32'h100, 1'b1, 32'h200);
      #1;
      chk("collide_jump_addr", jump_addr, 32'h300);
      step();
      drive(1'b1, 2'd0, '0, '0, 1'b0, '0);
      rd(5'd14, "collide_epc", 32'h200);

      // Reset while in the handler with a request pending.
      raise_irq();
      rd(5'd13, "prereset_cause", 32'h8000_0000);
      #1;
      rst_n = 1'b0;
      model_reset();
      oper = 2'd2;
      ir_in = 1'b0;
      #1;
      chk("midreset_jump_en", 32'(jump_en), 32'd0);
      rd(5'd12, "midreset_status", 32'h0);
      rd(5'd15, "midreset_ehbr", 32'h8);
      rd(5'd13, "midreset_cause", 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_reset_eret_en", 32'(jump_en), 32'd1);
      chk("post_reset_eret_addr", jump_addr, 32'h0);
      step();
      oper = 2'd0;
      rd(5'd12, "post_reset_status", 32'h0);

      // Randomized phase against the model.
      for (int i = 0; i < 400; i++) begin
         en        = ($urandom_range(0, 9) != 0);
         oper      = 2'($urandom_range(0, 3));
         addr_w    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
         data_w    = $urandom;
         ret_valid = ($urandom_range(0, 2) != 0);
         ret_addr  = $urandom;
         addr_r    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) ir_in = ~ir_in;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
